aes128_key_sched_ctrl: RTL

Iterative AES-128 key-expansion controller. It loads a 128-bit cipher key and emits round keys 0..10, one per accepted valid/ready handshake. The round constant for each step is generated internally from the round counter using the standard Rcon table. SubWord is done by an external shared 4-byte S-box slice through a combinational side port. The block sits between key load and the round datapath's AddRoundKey stage.

---
 rtl/aes128_key_sched_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aes128_key_sched_ctrl.sv
// Iterative AES-128 key-expansion controller.
// Loads a 128-bit cipher key and presents round keys 0..NUM_ROUNDS, one per accepted
// valid/ready handshake. SubWord uses an external combinational S-box slice.
module aes128_key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic [31:0]  sub_word_in,
  input  logic [31:0]  sub_word_out,
  output logic [127:0] round_key,
  output logic [3:0]   round_key_idx,
  output logic         round_key_valid,
  input  logic         round_key_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e        state_q;
  logic [127:0]  key_q;
  logic [3:0]    round_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot_word;
  logic [31:0]   temp;
  logic [31:0]   n0, n1, n2, n3;
  logic [127:0]  next_key;
  logic [3:0]    round_inc;
  logic          xfer;

  // Standard Rcon table; rounds outside 1..10 give zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Next round key from the current one; S-box lookup goes out through sub_word_in.
  always_comb begin
    w0          = key_q[127:96];
    w1          = key_q[95:64];
    w2          = key_q[63:32];
    w3          = key_q[31:0];
    rot_word    = {w3[23:0], w3[31:24]};
    sub_word_in = (state_q == StEmit) ? rot_word : 32'h0;
    round_inc   = round_q + 4'd1;
    temp        = sub_word_out ^ {rcon(round_inc), 24'h0};
    n0          = w0 ^ temp;
    n1          = w1 ^ n0;
    n2          = w2 ^ n1;
    n3          = w3 ^ n2;
    next_key    = {n0, n1, n2, n3};
    xfer        = valid_q && round_key_ready;
  end

  // Control FSM with registered outputs; abort overrides start and transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        key_q   <= '0;
        round_q <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q <= StEmit;
              key_q   <= key_in;
              round_q <= '0;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          StEmit: begin
            if (xfer) begin
              if (round_q == LastRound) begin
                // Clearing the key keeps round_key at zero while idle.
                state_q <= StIdle;
                key_q   <= '0;
                round_q <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                key_q   <= next_key;
                round_q <= round_inc;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign round_key       = key_q;
  assign round_key_idx   = round_q;
  assign round_key_valid = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
